// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: register read/write responder on the UART FIFO ports.
// Optional inter-byte abort timeout: define UART_REG_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge #(
    parameter int DBIT        = 8,
    parameter int NREG        = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DBIT-1:0]      r_data,
    input  logic                 rx_empty,
    output logic                 rd_uart,
    output logic [DBIT-1:0]      w_data,
    output logic                 wr_uart,
    input  logic                 tx_full,
    output logic [NREG*DBIT-1:0] reg_out,
    output logic                 wr_strobe,
    output logic [7:0]           wr_addr
);

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, SEND} state_t;

    localparam logic [DBIT-1:0] OP_W = 8'h57;
    localparam logic [DBIT-1:0] OP_R = 8'h52;
    localparam logic [DBIT-1:0] ACK  = 8'h4B;
    localparam logic [DBIT-1:0] BAD  = 8'h3F;
    localparam logic [8:0]      NREG9 = 9'(NREG);

    state_t                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [7:0]            addr_q, addr_d;
    logic [DBIT-1:0]       resp_q, resp_d;
    logic [NREG*DBIT-1:0]  regs_q, regs_d;
    logic                  stb_q, stb_d;
    logic [7:0]            waddr_q, waddr_d;
    logic [DBIT-1:0]       rd_val;
    logic                  pop;
    logic                  rd_ok;
    logic                  wr_ok;

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] to_q, to_d;
`endif

    assign pop       = reset_n && !rx_empty && (state_q != SEND);
    assign rd_uart   = pop;
    assign w_data    = resp_q;
    assign reg_out   = regs_q;
    assign wr_strobe = stb_q;
    assign wr_addr   = waddr_q;
    assign rd_ok     = {1'b0, r_data} < NREG9;
    assign wr_ok     = {1'b0, addr_q} < NREG9;

    // Read mux: register addressed by the byte at the FIFO head
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NREG; k++) begin
            if (r_data == 8'(k)) rd_val = regs_q[k*DBIT +: DBIT];
        end
    end

    // Command decode: next state, register writes and response byte
    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        regs_d  = regs_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wr_uart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (r_data == OP_W || r_data == OP_R) begin
                        is_wr_d = (r_data == OP_W);
                        state_d = GET_ADDR;
                    end else begin
                        resp_d  = BAD;
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (pop) begin
                    if (is_wr_q) begin
                        addr_d  = r_data;
                        state_d = GET_DATA;
                    end else begin
                        resp_d  = rd_ok ? rd_val : BAD;
                        state_d = SEND;
                    end
                end
            end
            GET_DATA: begin
                if (pop) begin
                    if (wr_ok) begin
                        for (int k = 0; k < NREG; k++) begin
                            if (addr_q == 8'(k)) regs_d[k*DBIT +: DBIT] = r_data;
                        end
                        stb_d   = 1'b1;
                        waddr_d = addr_q;
                    end
                    resp_d  = wr_ok ? ACK : BAD;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
        to_d = '0;
        if ((state_q == GET_ADDR || state_q == GET_DATA) && !pop) begin
            if (to_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end else if (to_q != '1) begin
                to_d = to_q + 1'b1;
            end else begin
                to_d = to_q;
            end
        end
`endif
    end

    // Protocol state and register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            resp_q  <= '0;
            regs_q  <= '0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            regs_q  <= regs_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
        end
    end

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    // Inter-byte idle counter for aborting stale commands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) to_q <= '0;
        else          to_q <= to_d;
    end
`endif

endmodule
